// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers dual-issue fetch pairs in a circular queue
// and presents up to two in-order instructions per cycle to decode.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst1,
  input  logic [31:0] fetch_inst2,
  input  logic        fetch_inst2_avail,
  output logic        hold_pc,
  output logic        inst2_taken,
  output logic        issue_valid0,
  output logic [31:0] issue_pc0,
  output logic [31:0] issue_inst0,
  output logic        issue_valid1,
  output logic [31:0] issue_pc1,
  output logic [31:0] issue_inst1,
  input  logic [1:0]  issue_num
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] mem_pc_q   [DEPTH];
  logic [31:0] mem_inst_q [DEPTH];

  logic [CNT_W-1:0] free_cnt;
  logic             push_ok;
  logic [1:0]       pushes;
  logic [1:0]       req;
  logic [1:0]       pops;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;

  // Flow control from registered occupancy only; pops never free space same cycle
  always_comb begin
    free_cnt    = DEPTH_CNT - count_q;
    hold_pc     = (count_q == DEPTH_CNT);
    push_ok     = fetch_valid & ~flush & ~hold_pc;
    inst2_taken = push_ok & fetch_inst2_avail & (free_cnt >= CNT_W'(2));
    pushes      = {1'b0, push_ok} + {1'b0, inst2_taken};
    req         = (issue_num == 2'd3) ? 2'd2 : issue_num;
    pops        = (CNT_W'(req) > count_q) ? count_q[1:0] : req;
    wr_ptr_p1   = wr_ptr_q + PTR_W'(1);
    rd_ptr_p1   = rd_ptr_q + PTR_W'(1);
  end

  // Next pointer and occupancy; flush empties the queue and ignores fetch/issue
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pops);
      wr_ptr_d = wr_ptr_q + PTR_W'(pushes);
      count_d  = count_q + CNT_W'(pushes) - CNT_W'(pops);
    end
  end

  // Pointer and occupancy registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, not reset; inst2 lands one slot after inst1
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_pc_q[wr_ptr_q]   <= fetch_pc;
      mem_inst_q[wr_ptr_q] <= fetch_inst1;
    end
    if (!rst && inst2_taken) begin
      mem_pc_q[wr_ptr_p1]   <= fetch_pc + 32'd4;
      mem_inst_q[wr_ptr_p1] <= fetch_inst2;
    end
  end

  // Issue window: head and head+1 read straight from storage, no bypass
  always_comb begin
    issue_valid0 = (count_q != '0);
    issue_valid1 = (count_q >= CNT_W'(2));
    issue_pc0    = mem_pc_q[rd_ptr_q];
    issue_inst0  = mem_inst_q[rd_ptr_q];
    issue_pc1    = mem_pc_q[rd_ptr_p1];
    issue_inst1  = mem_inst_q[rd_ptr_p1];
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_inst2_avail;
  logic [31:0] fetch_pc, fetch_inst1, fetch_inst2;
  logic        hold_pc, inst2_taken;
  logic        issue_valid0, issue_valid1;
  logic [31:0] issue_pc0, issue_inst0, issue_pc1, issue_inst1;
  logic [1:0]  issue_num;

  int n_vec = 0;
  int n_err = 0;
  int n_overreq = 0;

  logic [63:0] mq[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_inst1(fetch_inst1), .fetch_inst2(fetch_inst2),
    .fetch_inst2_avail(fetch_inst2_avail),
    .hold_pc(hold_pc), .inst2_taken(inst2_taken),
    .issue_valid0(issue_valid0), .issue_pc0(issue_pc0), .issue_inst0(issue_inst0),
    .issue_valid1(issue_valid1), .issue_pc1(issue_pc1), .issue_inst1(issue_inst1),
    .issue_num(issue_num)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive, check against model mid-cycle, then advance model at the edge
  task automatic cyc(input logic rs, input logic fl, input logic fv, input logic [31:0] pc,
                     input logic [31:0] i1, input logic [31:0] i2, input logic av,
                     input logic [1:0] num);
    bit exp_hold, exp_take, acc1;
    int sz, want, npop;
    rst = rs; flush = fl; fetch_valid = fv; fetch_pc = pc;
    fetch_inst1 = i1; fetch_inst2 = i2; fetch_inst2_avail = av; issue_num = num;
    #4;
    sz       = mq.size();
    exp_hold = (sz == DEPTH);
    acc1     = fv && !fl && !exp_hold;
    exp_take = acc1 && av && ((DEPTH - sz) >= 2);
    chk("hold_pc", 64'(hold_pc), 64'(exp_hold));
    chk("inst2_taken", 64'(inst2_taken), 64'(exp_take));
    chk("issue_valid0", 64'(issue_valid0), 64'(sz >= 1));
    chk("issue_valid1", 64'(issue_valid1), 64'(sz >= 2));
    if (sz >= 1) chk("slot0", {issue_pc0, issue_inst0}, mq[0]);
    if (sz >= 2) chk("slot1", {issue_pc1, issue_inst1}, mq[1]);
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
    end else begin
      want = (num > 2) ? 2 : int'(num);
      if (want > sz) n_overreq++;
      npop = (want > sz) ? sz : want;
      repeat (npop) void'(mq.pop_front());
      if (acc1) mq.push_back({pc, i1});
      if (exp_take) mq.push_back({pc + 32'd4, i2});
    end
    #1;
  endtask

  task automatic idle(input logic [1:0] num);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, num);
  endtask

  task automatic reset_dut();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
  endtask

  task automatic pair(input logic [31:0] pc, input logic av, input logic [1:0] num);
    cyc(1'b0, 1'b0, 1'b1, pc, pc ^ 32'h5A5A0000, pc ^ 32'hA5A50000, av, num);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    fetch_inst1 = '0; fetch_inst2 = '0; fetch_inst2_avail = 1'b0; issue_num = '0;
    @(posedge clk); #1;
    reset_dut();
    idle(2'd0);

    // First pair after reset, both accepted
    cyc(1'b0, 1'b0, 1'b1, 32'hBFC00000, 32'h11111111, 32'h22222222, 1'b1, 2'd0);
    chk("slot0_pc_const", 64'(issue_pc0), 64'(32'hBFC00000));
    chk("slot0_inst_const", 64'(issue_inst0), 64'(32'h11111111));
    chk("slot1_pc_const", 64'(issue_pc1), 64'(32'hBFC00004));
    chk("slot1_inst_const", 64'(issue_inst1), 64'(32'h22222222));
    idle(2'd0);

    // Fill to full, then a rejected fifth fetch, then drain
    reset_dut();
    for (int i = 0; i < 4; i++) pair(32'h1000 + 32'(i * 8), 1'b1, 2'd0);
    chk("full_hold", 64'(hold_pc), 64'd1);
    pair(32'h2000, 1'b1, 2'd0);
    pair(32'h3000, 1'b1, 2'd2);
    repeat (5) idle(2'd2);

    // count=7: inst2 refused, only inst1 enqueued
    reset_dut();
    for (int i = 0; i < 3; i++) pair(32'h4000 + 32'(i * 8), 1'b1, 2'd0);
    pair(32'h4100, 1'b0, 2'd0);
    pair(32'h80001000, 1'b1, 2'd0);
    repeat (5) idle(2'd2);

    // Steady count=4 with concurrent push and pop across several pointer wraps
    reset_dut();
    pair(32'h5000, 1'b1, 2'd0);
    pair(32'h5008, 1'b1, 2'd0);
    for (int i = 0; i < 12; i++) pair(32'h6000 + 32'(i * 8), 1'b1, 2'd2);
    repeat (3) idle(2'd2);

    // Flush with a concurrent fetch
    reset_dut();
    pair(32'h7000, 1'b1, 2'd0);
    pair(32'h7008, 1'b1, 2'd0);
    pair(32'h7010, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 1'b1, 32'h7100, 32'h1, 32'h2, 1'b1, 2'd1);
    chk("post_flush_valid0", 64'(issue_valid0), 64'd0);
    pair(32'h7200, 1'b1, 2'd0);
    chk("post_flush_slot0", 64'(issue_pc0), 64'(32'h7200));
    idle(2'd0);

    // Over-request clamp and pop from empty
    reset_dut();
    pair(32'h7300, 1'b0, 2'd0);
    idle(2'd2);
    idle(2'd1);
    idle(2'd3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 31) == 0),
          1'($urandom_range(0, 3) != 0), {$urandom()} & 32'hFFFF_FFFC,
          $urandom(), $urandom(), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
